// File: rtl/change_dispenser.sv
// Coin-return engine: pays out change (or a full refund) as timed 500/100
// coin-release pulses, greedy order, and strobes done when finished.
module change_dispenser #(
    parameter int WIDTH        = 5,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] monto,
    input  logic [WIDTH-1:0] cost,
    output logic             coin500,
    output logic             coin100,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             short
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [WIDTH-1:0] AMT_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] AMT_ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] AMT_FIVE   = WIDTH'(5);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EVAL  = 3'd1,
        PULSE = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sel500_r;
    logic [WIDTH-1:0] latch_amt_s;
    logic             latch_short_s;

    // Amount to pay out for a request; subtract only after the compare so it never wraps.
    always_comb begin
        latch_amt_s   = AMT_ZERO;
        latch_short_s = 1'b0;
        if (cancel) begin
            latch_amt_s   = monto;
            latch_short_s = 1'b0;
        end else if (monto >= cost) begin
            latch_amt_s   = monto - cost;
            latch_short_s = 1'b0;
        end else begin
            latch_amt_s   = AMT_ZERO;
            latch_short_s = 1'b1;
        end
    end

    // Payout FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            sel500_r  <= 1'b0;
            coin500   <= 1'b0;
            coin100   <= 1'b0;
            remaining <= AMT_ZERO;
            busy      <= 1'b0;
            done      <= 1'b0;
            short     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    coin500 <= 1'b0;
                    coin100 <= 1'b0;
                    done    <= 1'b0;
                    cnt_r   <= CNT_ZERO;
                    if (start) begin
                        remaining <= latch_amt_s;
                        short     <= latch_short_s;
                        busy      <= 1'b1;
                        state_r   <= EVAL;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                EVAL: begin
                    cnt_r <= CNT_ZERO;
                    if (remaining >= AMT_FIVE) begin
                        sel500_r <= 1'b1;
                        coin500  <= 1'b1;
                        coin100  <= 1'b0;
                        state_r  <= PULSE;
                    end else if (remaining != AMT_ZERO) begin
                        sel500_r <= 1'b0;
                        coin500  <= 1'b0;
                        coin100  <= 1'b1;
                        state_r  <= PULSE;
                    end else begin
                        coin500 <= 1'b0;
                        coin100 <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end
                end
                PULSE: begin
                    if (cnt_r == PULSE_LAST) begin
                        coin500   <= 1'b0;
                        coin100   <= 1'b0;
                        remaining <= remaining - (sel500_r ? AMT_FIVE : AMT_ONE);
                        cnt_r     <= CNT_ZERO;
                        state_r   <= GAP;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= PULSE;
                    end
                end
                GAP: begin
                    coin500 <= 1'b0;
                    coin100 <= 1'b0;
                    if (cnt_r == GAP_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= EVAL;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= GAP;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= CNT_ZERO;
                    coin500   <= 1'b0;
                    coin100   <= 1'b0;
                    remaining <= AMT_ZERO;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-return engine for the coffee vending machine. It is the money-out counterpart of the coin adder: on a start strobe it takes the accumulated amount and the drink cost, then emits change as timed 500 and 100 coin-release pulses. On a cancel it refunds the whole inserted amount instead. It sits beside the coin adder and cost comparator and is driven by the machine's main FSM; `done` tells that FSM the payout is finished.

## Interface
- `WIDTH`, default 5: width of amounts, in units of 100 (max 31 → 3100).
- `PULSE_CYCLES`, default 2: cycles each coin-release output stays high (≥1).
- `GAP_CYCLES`, default 2: low cycles after each coin pulse (≥1).

Ports:
- `clk`  in  1  system clock, single clock domain; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request payout; sampled only in IDLE.
- `cancel`  in  1  sampled with `start`; 1 = refund the full `monto`.
- `monto`  in  WIDTH  inserted amount, in units of 100; sampled with `start`.
- `cost`  in  WIDTH  drink cost, in units of 100; sampled with `start`.
- `coin500`  out  1  release one 500 coin while high.
- `coin100`  out  1  release one 100 coin while high.
- `remaining`  out  WIDTH  change still owed, in units of 100.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle strobe at end of payout.
- `short`  out  1  last request had `monto` < `cost` without cancel.

## Operation
- States: IDLE, EVAL, PULSE, GAP, DONE.
- IDLE → EVAL when `start`=1. On that edge the block latches `remaining`:
  - `cancel`=1: `remaining` = `monto`; `short` cleared.
  - `cancel`=0, `monto` ≥ `cost`: `remaining` = `monto` − `cost`; `short` cleared.
  - `cancel`=0, `monto` < `cost`: `remaining` = 0; `short` set.
- The subtraction is done in WIDTH bits, only after the compare, so it never wraps.
- EVAL, based on `remaining`:
  - ≥ 5: select 500, go to PULSE.
  - 1–4: select 100, go to PULSE.
  - 0: go to DONE.
- PULSE: the selected coin output is high for exactly PULSE_CYCLES cycles, and only one coin output is high at a time. On the last PULSE cycle, `remaining` decreases by 5 (500 coin) or 1 (100 coin). Then go to GAP.
- GAP: both coin outputs low for GAP_CYCLES cycles, then go to EVAL.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `short` holds its value until the next accepted `start` or `rst`.
- While `busy`, `start`, `cancel`, `monto` and `cost` are ignored; the latched values rule.
- Coin order is greedy: all 500 coins first, then 100 coins. Coin count = remaining/5 + remaining%5.

## Timing
- Reset values: state IDLE; all outputs 0.
- A `rst` asserted mid-payout forces IDLE on the next edge. Any coin pulse is truncated, no `done` is issued, and `remaining` is cleared.
- `start` accepted at edge 0:
  - EVAL in cycle 1.
  - First coin output high in cycles 2 … PULSE_CYCLES+1.
  - Each coin costs 1 + PULSE_CYCLES + GAP_CYCLES cycles.
- Zero-change or short request: EVAL in cycle 1, `done` in cycle 2, IDLE in cycle 3.
- `busy` rises in cycle 1 and falls together with the return to IDLE (the cycle after `done`).
- `start` held high across DONE→IDLE starts a new payout on the IDLE cycle. A level-held `start` re-triggers, so the issuing FSM must pulse it.
- `remaining` updates only on the latch edge and on last-PULSE-cycle edges.

## Test plan
- Reset, then `start`=1, `monto`=7, `cost`=1, `cancel`=0, defaults:
  - `coin500` high cycles 2–3, then `coin100` high cycles 7–8.
  - `remaining` goes 6 → 1 → 0.
  - `done` in cycle 12; `busy` low from cycle 13.
- `monto`=2, `cost`=4, `cancel`=0 → no coin pulses, `short`=1, `done` in cycle 2. `short` clears on the next accepted start.
- `monto`=11, `cost`=3, `cancel`=1 → refund of 11: 500, 500, 100 in that order, `short`=0.
- Exact payment, `monto`=`cost`=4 → no coins, `done` in cycle 2.
- Mid-payout: `start` pulse with new values during PULSE is ignored, and payout completes unchanged. Then `rst` asserted during a `coin500` pulse → `coin500`=0, `busy`=0, `remaining`=0 next cycle, no `done`.
- Maximum value: `monto`=31, `cost`=0, PULSE_CYCLES=1, GAP_CYCLES=1:
  - six 500 pulses then one 100 pulse, each 3 cycles apart.
  - `coin500` and `coin100` never high together.
  - `done` in cycle 23.
